otsu_hist_ctrl: RTL and testbench
=================================

// Module: otsu_hist_ctrl
// PURPOSE
//  Frame-level sequencer for Otsu thresholding.
//  - Owns a 256-bin grey-level histogram and clears it each frame.
//  - Accumulates one frame of streamed grey pixels into the bins.
//  - Streams the bins in order to the downstream Otsu variance evaluator.
//  - Waits for the evaluator's threshold, latches it for the pixel-threshold stage, and flags done.
// PARAMETERS
//  PIX_COUNT  393216  pixels per frame (768*512); ACCUM ends after this many accepted pixels
//  CNT_W      19      bin counter width; must satisfy 2^CNT_W-1 >= PIX_COUNT
// PORTS
//  HCLK         in   1      clock; all logic on posedge
//  HRESET       in   1      synchronous reset, active-high
//  start        in   1      frame start pulse; honoured only in IDLE or DONE
//  busy         out  1      high in CLEAR, ACCUM, SCAN, WAIT_THR
//  pix_valid    in   1      grey pixel valid
//  pix_gray     in   8      grey pixel value
//  pix_ready    out  1      high only in ACCUM
//  bin_valid    out  1      histogram bin output valid (SCAN only)
//  bin_ready    in   1      evaluator accepts bin
//  bin_idx      out  8      bin index 0..255
//  bin_cnt      out  CNT_W  count for bin_idx
//  bin_last     out  1      high with bin_idx==255
//  eval_thr_vld in   1      evaluator result strobe
//  eval_thr     in   8      evaluator threshold
//  thr_out      out  8      latched threshold for the threshold stage
//  thr_vld      out  1      thr_out holds a valid result
//  done         out  1      one-cycle pulse on entering DONE
// BEHAVIOUR
//  Reset: state=IDLE; all bins=0; thr_out=0; thr_vld=0.
//   Reset drives 0 on busy, pix_ready, bin_valid, bin_idx, bin_cnt, bin_last and done.
//   Reset in any state aborts the frame immediately; no partial result is latched.
//  FSM: IDLE -start-> CLEAR -> ACCUM -> SCAN -> WAIT_THR -> DONE -start-> CLEAR.
//   start in any other state is ignored.
//  CLEAR:
//   - Writes 0 to bin[clr_idx]; clr_idx steps 0..255, one bin per cycle.
//   - Lasts exactly 256 cycles, then goes to ACCUM. thr_vld is kept.
//  ACCUM:
//   - pix_ready=1. Each cycle with pix_valid=1: bin[pix_gray] += 1, and pix_cnt += 1.
//   - Bin counts saturate at 2^CNT_W-1.
//   - Back-to-back equal pixel values must each count (single-cycle read-modify-write, no lost updates).
//   - When the accepted pixel is number PIX_COUNT, the state becomes SCAN on the next cycle.
//     pix_ready is low from that cycle onward.
//  SCAN:
//   - Valid/ready stream starting at bin_idx=0. bin_cnt=bin[bin_idx].
//   - A transfer occurs when bin_valid && bin_ready. bin_idx increments on each transfer.
//   - bin_valid and all payload are held stable while bin_ready=0.
//   - The transfer with bin_idx=255 (bin_last=1) moves to WAIT_THR, and bin_valid drops on the next cycle.
//   - Minimum SCAN length is 256 cycles.
//  WAIT_THR:
//   - The first cycle with eval_thr_vld=1 latches eval_thr into thr_out, sets thr_vld=1, and goes to DONE.
//   - eval_thr_vld in any other state is ignored.
//  DONE: done=1 for the single entry cycle; busy=0. thr_out and thr_vld hold until the next result latch or reset.
//  thr_out is registered; it changes only on the WAIT_THR latch edge.
// TESTING
//  T1 reset/idle: hold HRESET 3 cycles, no start -> all outputs 0, pix_ready=0, state IDLE.
//  T2 uniform frame (PIX_COUNT=1024 override, gray=i%256, pix_valid always 1, bin_ready=1):
//     -> 256 CLEAR cycles, then 1024 ACCUM cycles; every bin_cnt=4.
//     -> bin_last on idx 255; eval_thr=0x7F one cycle later gives thr_out=0x7F, thr_vld=1, done pulse.
//  T3 backpressure (PIX_COUNT=1024): bin_ready toggling with random 30% duty
//     -> bin_idx/bin_cnt are stable while stalled; there are exactly 256 transfers with no skip or duplicate.
//  T4 same-value burst (PIX_COUNT=1024): 1000 pixels of 0xC8 back-to-back, then 24 of 0x00
//     -> bin[200]=1000, bin[0]=24, all other bins 0.
//  T5 ignored events: start during ACCUM and eval_thr_vld during SCAN -> no state change, thr_out unchanged.
//  T6 mid-frame reset (PIX_COUNT=1024): HRESET asserted at pixel 500 of frame 2
//     -> thr_vld=0 and bins 0; a new start then runs a full clean frame.

Source files
------------

// File: rtl/otsu_hist_ctrl.sv
// Frame sequencer for Otsu thresholding: owns the 256-bin grey histogram,
// clears it, accumulates one frame of pixels, streams the bins to the
// variance evaluator and latches the returned threshold.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   S_IDLE     | after reset, waiting for start
//   S_CLEAR    | zeroing one bin per cycle, clr_idx 0..255
//   S_ACCUM    | pix_ready high, counting accepted pixels into bins
//   S_SCAN     | valid/ready stream of bins 0..255 to the evaluator
//   S_WAIT_THR | waiting for the evaluator's threshold strobe
//   S_DONE     | result latched, waiting for the next start
module otsu_hist_ctrl #(
  parameter int PIX_COUNT = 393216,
  parameter int CNT_W     = 19
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  output logic             busy,
  input  logic             pix_valid,
  input  logic [7:0]       pix_gray,
  output logic             pix_ready,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic [7:0]       bin_idx,
  output logic [CNT_W-1:0] bin_cnt,
  output logic             bin_last,
  input  logic             eval_thr_vld,
  input  logic [7:0]       eval_thr,
  output logic [7:0]       thr_out,
  output logic             thr_vld,
  output logic             done
);

  localparam int              PC_W     = $clog2(PIX_COUNT + 1);
  localparam logic [PC_W-1:0] PIX_LAST = PC_W'(PIX_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_SCAN, S_WAIT_THR, S_DONE
  } state_e;

  state_e           state_q;
  logic [7:0]       clr_idx_q;
  logic [PC_W-1:0]  pix_cnt_q;
  logic             busy_q;
  logic             pix_ready_q;
  logic             bin_valid_q;
  logic [7:0]       bin_idx_q;
  logic             bin_last_q;
  logic [7:0]       thr_out_q;
  logic             thr_vld_q;
  logic             done_q;

  logic [CNT_W-1:0] bins_q [256];
  logic [CNT_W-1:0] bin_rd;
  logic [CNT_W-1:0] bin_inc_d;
  logic             pix_fire;

  assign pix_fire = pix_valid && pix_ready_q;

  // Saturating increment of the addressed bin; read and write land in the
  // same cycle so back-to-back equal pixels never lose an update.
  always_comb begin
    bin_rd    = bins_q[pix_gray];
    bin_inc_d = (bin_rd == CNT_MAX) ? bin_rd : bin_rd + CNT_W'(1);
  end

  // Histogram storage: cleared by reset, by the CLEAR sweep, bumped on accepted pixels.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < 256; i++) bins_q[i] <= '0;
    end else if (state_q == S_CLEAR) begin
      bins_q[clr_idx_q] <= '0;
    end else if (pix_fire) begin
      bins_q[pix_gray] <= bin_inc_d;
    end
  end

  // Frame sequencer with all status/handshake outputs registered.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      clr_idx_q   <= '0;
      pix_cnt_q   <= '0;
      busy_q      <= 1'b0;
      pix_ready_q <= 1'b0;
      bin_valid_q <= 1'b0;
      bin_idx_q   <= '0;
      bin_last_q  <= 1'b0;
      thr_out_q   <= '0;
      thr_vld_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_CLEAR;
            busy_q    <= 1'b1;
            clr_idx_q <= '0;
          end
        end
        S_CLEAR: begin
          clr_idx_q <= clr_idx_q + 8'd1;
          if (clr_idx_q == 8'hFF) begin
            state_q     <= S_ACCUM;
            pix_ready_q <= 1'b1;
            pix_cnt_q   <= '0;
          end
        end
        S_ACCUM: begin
          if (pix_valid) begin
            pix_cnt_q <= pix_cnt_q + PC_W'(1);
            if (pix_cnt_q == PIX_LAST) begin
              state_q     <= S_SCAN;
              pix_ready_q <= 1'b0;
              bin_valid_q <= 1'b1;
              bin_idx_q   <= '0;
              bin_last_q  <= 1'b0;
            end
          end
        end
        S_SCAN: begin
          if (bin_ready) begin
            if (bin_last_q) begin
              state_q     <= S_WAIT_THR;
              bin_valid_q <= 1'b0;
              bin_last_q  <= 1'b0;
              bin_idx_q   <= '0;
            end else begin
              bin_idx_q  <= bin_idx_q + 8'd1;
              bin_last_q <= (bin_idx_q == 8'hFE);
            end
          end
        end
        S_WAIT_THR: begin
          if (eval_thr_vld) begin
            state_q   <= S_DONE;
            thr_out_q <= eval_thr;
            thr_vld_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign pix_ready = pix_ready_q;
  assign bin_valid = bin_valid_q;
  assign bin_idx   = bin_idx_q;
  assign bin_cnt   = bin_valid_q ? bins_q[bin_idx_q] : '0;
  assign bin_last  = bin_last_q;
  assign thr_out   = thr_out_q;
  assign thr_vld   = thr_vld_q;
  assign done      = done_q;

endmodule

// File: tb/tb_otsu_hist_ctrl.sv
// Bench for otsu_hist_ctrl: frame-level reference model plus per-cycle compare.
module tb_otsu_hist_ctrl;
  localparam int PIX_COUNT = 1024;
  localparam int CNT_W     = 19;
  localparam int MAXC      = (1 << CNT_W) - 1;

  localparam int P_IDLE = 0, P_CLEAR = 1, P_ACCUM = 2, P_SCAN = 3, P_WAIT = 4, P_DONE = 5;

  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  logic             start = 1'b0;
  logic             pix_valid = 1'b0;
  logic [7:0]       pix_gray = 8'd0;
  logic             bin_ready = 1'b0;
  logic             eval_thr_vld = 1'b0;
  logic [7:0]       eval_thr = 8'd0;
  logic             busy, pix_ready, bin_valid, bin_last, thr_vld, done;
  logic [7:0]       bin_idx, thr_out;
  logic [CNT_W-1:0] bin_cnt;

  otsu_hist_ctrl #(.PIX_COUNT(PIX_COUNT), .CNT_W(CNT_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .busy(busy),
    .pix_valid(pix_valid), .pix_gray(pix_gray), .pix_ready(pix_ready),
    .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_idx(bin_idx),
    .bin_cnt(bin_cnt), .bin_last(bin_last), .eval_thr_vld(eval_thr_vld),
    .eval_thr(eval_thr), .thr_out(thr_out), .thr_vld(thr_vld), .done(done)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase of the frame plus the histogram implied by accepted pixels.
  int         m_phase = P_IDLE;
  int         m_clr, m_pix, m_idx;
  int         m_hist [256];
  logic [7:0] m_thr = 8'd0;
  bit         m_thrv = 1'b0;
  bit         m_done = 1'b0;
  bit         m_live = 1'b0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      m_phase = P_IDLE;
      foreach (m_hist[i]) m_hist[i] = 0;
      m_thr  = 8'd0;
      m_thrv = 1'b0;
      m_done = 1'b0;
      m_idx  = 0;
      m_live = 1'b1;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        P_IDLE, P_DONE: if (start) begin m_phase = P_CLEAR; m_clr = 0; end
        P_CLEAR: begin
          m_clr++;
          if (m_clr == 256) begin
            m_phase = P_ACCUM;
            m_pix = 0;
            foreach (m_hist[i]) m_hist[i] = 0;
          end
        end
        P_ACCUM: if (pix_valid) begin
          if (m_hist[pix_gray] < MAXC) m_hist[pix_gray]++;
          m_pix++;
          if (m_pix == PIX_COUNT) begin m_phase = P_SCAN; m_idx = 0; end
        end
        P_SCAN: if (bin_ready) begin
          if (m_idx == 255) m_phase = P_WAIT;
          else m_idx++;
        end
        P_WAIT: if (eval_thr_vld) begin
          m_thr = eval_thr; m_thrv = 1'b1; m_done = 1'b1; m_phase = P_DONE;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Captured scan stream of the current frame.
  int cap  [256];
  int hits [256];
  int n_xfer;

  always @(negedge HCLK) begin
    if (m_live) begin
      chk("busy", 32'(busy), 32'(m_phase inside {P_CLEAR, P_ACCUM, P_SCAN, P_WAIT}));
      chk("pix_ready", 32'(pix_ready), 32'(m_phase == P_ACCUM));
      chk("bin_valid", 32'(bin_valid), 32'(m_phase == P_SCAN));
      if (m_phase == P_SCAN) begin
        chk("bin_idx", 32'(bin_idx), 32'(m_idx));
        chk("bin_cnt", 32'(bin_cnt), 32'(m_hist[m_idx]));
        chk("bin_last", 32'(bin_last), 32'(m_idx == 255));
      end
      chk("thr_out", 32'(thr_out), 32'(m_thr));
      chk("thr_vld", 32'(thr_vld), 32'(m_thrv));
      chk("done", 32'(done), 32'(m_done));
      if (bin_valid && bin_ready) begin
        cap[bin_idx] = 32'(bin_cnt);
        hits[bin_idx]++;
        n_xfer++;
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // mode 0: gray = pixel index % 256, 1: random gray, 2: 1000 x 0xC8 then 0x00
  task automatic run_frame(input int mode, input int pv_pct, input int br_pct,
                           input logic [7:0] thr_val, input bit rnd_delay, input bit inject,
                           input int abort_at, output int clr_cyc, output int acc_cyc,
                           output bit thr_moved);
    int   pix_idx = 0;
    int   cyc = 0;
    bit   wait_seen = 1'b0;
    bit   seen_ready = 1'b0;
    bit   inj_thr = 1'b0;
    bit   fire_pix, fire_last;
    logic [7:0] thr_start;
    clr_cyc = 0; acc_cyc = 0; thr_moved = 1'b0;
    foreach (cap[i]) begin cap[i] = 0; hits[i] = 0; end
    n_xfer = 0;
    thr_start = thr_out;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!done && cyc < 6000) begin
      if (busy && !pix_ready && !seen_ready) clr_cyc++;
      if (pix_ready) begin seen_ready = 1'b1; acc_cyc++; end
      if (thr_out !== thr_start) thr_moved = 1'b1;
      pix_valid = (pv_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pv_pct);
      case (mode)
        0:       pix_gray = 8'(pix_idx % 256);
        1:       pix_gray = 8'($urandom_range(0, 255));
        default: pix_gray = (pix_idx < 1000) ? 8'hC8 : 8'h00;
      endcase
      bin_ready = (br_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < br_pct);
      start = inject && pix_ready && (pix_idx == 300);
      if (inject && bin_valid && n_xfer == 10 && !inj_thr) begin
        eval_thr_vld = 1'b1; eval_thr = 8'hAA; inj_thr = 1'b1;
      end else begin
        eval_thr_vld = wait_seen && (!rnd_delay || $urandom_range(0, 3) == 0);
        eval_thr = wait_seen ? thr_val : 8'(~thr_val);
      end
      fire_pix  = pix_valid && pix_ready;
      fire_last = bin_valid && bin_ready && bin_last;
      step();
      if (fire_pix) pix_idx++;
      if (fire_last) wait_seen = 1'b1;
      cyc++;
      if (abort_at >= 0 && pix_idx == abort_at) begin
        HRESET = 1'b1; start = 1'b0; pix_valid = 1'b0; eval_thr_vld = 1'b0;
        step(); step();
        HRESET = 1'b0;
        return;
      end
    end
    start = 1'b0;
    chk("frame_done", 32'(done), 32'd1);
    eval_thr_vld = 1'b0;
    pix_valid = 1'b0;
    bin_ready = 1'b0;
  endtask

  function automatic int count_eq(input int v);
    int n = 0;
    foreach (cap[i]) if (cap[i] == v) n++;
    return n;
  endfunction

  function automatic int unique_hits();
    int n = 0;
    foreach (hits[i]) if (hits[i] == 1) n++;
    return n;
  endfunction

  initial begin
    int  clr_c, acc_c, sum;
    bit  moved;

    // T1 reset / idle
    HRESET = 1'b1;
    repeat (3) step();
    HRESET = 1'b0;
    step();
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_pix_ready", 32'(pix_ready), 32'd0);
    chk("t1_bin_valid", 32'(bin_valid), 32'd0);
    chk("t1_bin_idx", 32'(bin_idx), 32'd0);
    chk("t1_bin_cnt", 32'(bin_cnt), 32'd0);
    chk("t1_bin_last", 32'(bin_last), 32'd0);
    chk("t1_thr_out", 32'(thr_out), 32'd0);
    chk("t1_thr_vld", 32'(thr_vld), 32'd0);
    chk("t1_done", 32'(done), 32'd0);

    // T2 uniform frame
    run_frame(0, 100, 100, 8'h7F, 1'b0, 1'b0, -1, clr_c, acc_c, moved);
    chk("t2_clear_cycles", 32'(clr_c), 32'd256);
    chk("t2_accum_cycles", 32'(acc_c), 32'd1024);
    chk("t2_transfers", 32'(n_xfer), 32'd256);
    chk("t2_bins_eq4", 32'(count_eq(4)), 32'd256);
    chk("t2_thr_out", 32'(thr_out), 32'h7F);
    chk("t2_thr_vld", 32'(thr_vld), 32'd1);
    step();
    chk("t2_done_pulse_width", 32'(done), 32'd0);

    // T3 backpressure with random pixels and 30% ready duty
    run_frame(1, 80, 30, 8'h4C, 1'b1, 1'b0, -1, clr_c, acc_c, moved);
    sum = 0;
    foreach (cap[i]) sum += cap[i];
    chk("t3_transfers", 32'(n_xfer), 32'd256);
    chk("t3_unique_idx", 32'(unique_hits()), 32'd256);
    chk("t3_bin_sum", 32'(sum), 32'd1024);
    chk("t3_thr_out", 32'(thr_out), 32'h4C);

    // T4 same-value burst
    run_frame(2, 100, 100, 8'h10, 1'b0, 1'b0, -1, clr_c, acc_c, moved);
    chk("t4_bin200", 32'(cap[200]), 32'd1000);
    chk("t4_bin0", 32'(cap[0]), 32'd24);
    chk("t4_zero_bins", 32'(count_eq(0)), 32'd254);

    // T5 ignored start during ACCUM and ignored eval strobe during SCAN
    run_frame(0, 100, 70, 8'h33, 1'b0, 1'b1, -1, clr_c, acc_c, moved);
    chk("t5_accum_cycles", 32'(acc_c), 32'd1024);
    chk("t5_thr_held", 32'(moved), 32'd0);
    chk("t5_transfers", 32'(n_xfer), 32'd256);
    chk("t5_thr_out", 32'(thr_out), 32'h33);

    // T6 reset at pixel 500 of the next frame, then a clean frame
    run_frame(0, 100, 100, 8'h22, 1'b0, 1'b0, 500, clr_c, acc_c, moved);
    chk("t6_thr_vld", 32'(thr_vld), 32'd0);
    chk("t6_thr_out", 32'(thr_out), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    run_frame(0, 100, 100, 8'h5A, 1'b0, 1'b0, -1, clr_c, acc_c, moved);
    chk("t6_clean_bins", 32'(count_eq(4)), 32'd256);
    chk("t6_thr_out_new", 32'(thr_out), 32'h5A);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
